bdc_frame_scheduler: RTL and testbench
======================================

// Module: bdc_frame_scheduler
// PURPOSE
//  Frame/row sequencer for the barrel distortion correction line-buffer datapath. Owns the input
//  AXI4-Stream ready and tracks the input write position. Issues output (x,y) coordinates to the
//  remap datapath only when every source row the window needs is resident. Throttles input so
//  that no row still needed is overwritten. One clock domain, sits between the video source and
//  the remap/line-buffer core.
// PARAMETERS
//  WIDTH         1920  active pixels per line
//  HEIGHT        1080  active lines per frame
//  COORD_WIDTH   16    coordinate/counter width; must hold max(WIDTH,HEIGHT)
//  BUFFER_LINES  4     line-buffer depth in rows; power of two
//  LEAD_LINES    1     rows below out_row the remap may read
//  BACK_LINES derived = BUFFER_LINES-LEAD_LINES-2 (rows above out_row); elaboration error if <0
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    async active-low reset
//  s_axis_tvalid  in   1    source beat valid
//  s_axis_tlast   in   1    source end-of-line
//  s_axis_tuser   in   1    source start-of-frame
//  s_axis_tready  out  1    scheduler grants input; datapath write enable = tvalid&tready
//  wr_x           out  CW   column of the beat currently offered (in_x)
//  wr_slot        out  log2(BUFFER_LINES)  buffer row slot = in_lines mod BUFFER_LINES
//  in_lines       out  CW   complete input rows received this frame
//  gen_valid      out  1    output coordinate valid to remap datapath
//  gen_ready      in   1    remap datapath accepts coordinate
//  gen_x, gen_y   out  CW   output coordinate
//  gen_sof        out  1    gen beat is (0,0)
//  gen_eol        out  1    gen_x==WIDTH-1
//  gen_eof        out  1    gen beat is (WIDTH-1,HEIGHT-1)
//  busy           out  1    state!=IDLE
//  frame_done     out  1    1-cycle pulse after gen_eof beat accepted
//  err_sof        out  1    1-cycle pulse: tuser beat accepted mid-frame
//  err_eol        out  1    1-cycle pulse: tlast disagrees with in_x==WIDTH-1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0. s_axis_tready rises first cycle after
//  deassert.
//  States: IDLE -> FILL on accepted tuser beat. FILL -> RUN when row_ok(0).
//  RUN -> DRAIN when in_lines==HEIGHT. DRAIN -> IDLE on accepted gen_eof beat.
//  IDLE: tready=1. Non-tuser beats are accepted and discarded; counters unchanged.
//  Input (FILL/RUN): tready = (in_lines <= out_row+LEAD_LINES+1) && (in_lines < HEIGHT).
//  DRAIN: tready=0.
//  Line end = accepted beat with in_x==WIDTH-1: in_x->0, in_lines+1.
//  If tlast differs from that condition, pulse err_eol; counting ignores tlast.
//  The SOF beat is column 0 of row 0, so in_x=1 after it.
//  row_ok(y) = in_lines > min(y+LEAD_LINES, HEIGHT-1).
//  gen_valid = (state==RUN||DRAIN) && row_ok(gen_y). It is combinational from registers only,
//  with no path from gen_ready.
//  Accepted gen beat: gen_x++, or at WIDTH-1 gen_x->0 and gen_y++. out_row==gen_y.
//  One coordinate per cycle at full rate.
//  Once gen_valid is high it stays high until accepted, except on err_sof or reset.
//  Row release: rows < out_row-BACK_LINES are free. The input guard alone guarantees the
//  overwritten slot holds a released row.
//  Simultaneous: an input line end and a gen row end in one cycle both take effect; ready and
//  row_ok are then re-evaluated from the new counters.
//  err_sof: a tuser beat accepted in FILL/RUN/DRAIN pulses err_sof, forces gen_valid low
//  (downstream flushes on err_sof), clears counters, and treats the beat as pixel (0,0)
//  (in_x=1), with state FILL. In DRAIN tready=0, so this cannot occur there.
//  Last row: row_ok saturates at HEIGHT-1, so rows HEIGHT-LEAD..HEIGHT-1 issue once all rows are
//  in. After the frame_done pulse, state is IDLE and the next SOF is accepted.
//  Counters are never compared across frames and do not wrap within a frame.
//  Reset mid-frame: immediate return to reset values, with no partial output.
// STRUCTURE
//  bdc_pkg: state enum (IDLE/FILL/RUN/DRAIN), COORD_WIDTH default, clog2-based SLOT_W function.
//  Sub-module bdc_in_tracker: in_x/in_lines/wr_slot counters plus err_eol. Scheduler top: FSM,
//  ready/row_ok compare, gen counters.
// TESTING (WIDTH=8 HEIGHT=6 BUFFER_LINES=4 LEAD_LINES=1)
//  Reset: hold rst_n=0 -> all outputs 0. Release -> tready=1 next cycle, busy=0.
//  Free-running frame, gen_ready=1, tvalid=1 -> gen_valid first high after in_lines=2.
//    tready drops with in_lines=3 until out_row=1. 48 gen beats in raster order.
//    gen_sof on (0,0), gen_eof on (7,5), frame_done one cycle after.
//  gen_ready=0 whole frame -> in_lines stalls at 3, tready=0, no beats lost. Release gen_ready
//    -> frame completes with 48 input beats accepted.
//  3 beats tuser=0 in IDLE -> accepted, in_x stays 0, busy=0. tlast on column 5 -> err_eol
//    pulse, line still ends at column 7.
//  tuser beat at row 2 col 3 -> err_sof pulse, gen_valid=0, in_lines=0, in_x=1, state FILL.
//    The new frame then completes normally.
//  rst_n pulse mid-RUN -> outputs 0 asynchronously. The next SOF restarts a clean frame.

Source files
------------

// File: rtl/bdc_pkg.sv
// Shared types and helpers for the barrel distortion correction frame scheduler.
// Holds the scheduler state encoding, default coordinate width and slot-width helper.
package bdc_pkg;

  localparam int CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int slot_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/bdc_in_tracker.sv
// Input write-position tracker: column, completed rows, buffer slot and tlast check.
// Ports: restart/beat strobes in, tlast in; in_x, in_lines, wr_slot, err_eol out.
module bdc_in_tracker
  import bdc_pkg::*;
#(
  parameter int WIDTH        = 1920,
  parameter int COORD_WIDTH  = CW_DEFAULT,
  parameter int BUFFER_LINES = 4,
  parameter int SLOT_W       = slot_w(BUFFER_LINES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   beat,
  input  logic                   tlast,
  output logic [COORD_WIDTH-1:0] in_x,
  output logic [COORD_WIDTH-1:0] in_lines,
  output logic [SLOT_W-1:0]      wr_slot,
  output logic                   err_eol
);

  localparam int CW = COORD_WIDTH;
  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);

  logic at_end;

  // A restart beat is pixel (0,0) regardless of the current column.
  assign at_end = restart ? (X_LAST == '0)
                          : (in_x == X_LAST);

  assign wr_slot = (BUFFER_LINES > 1)
                 ? in_lines[SLOT_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_x     <= '0;
      in_lines <= '0;
      err_eol  <= 1'b0;
    end else begin
      err_eol <= (restart | beat) & (tlast != at_end);
      if (restart) begin
        in_x     <= at_end ? '0 : CW'(1);
        in_lines <= at_end ? CW'(1) : '0;
      end else if (beat) begin
        if (at_end) begin
          in_x     <= '0;
          in_lines <= in_lines + CW'(1);
        end else begin
          in_x <= in_x + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bdc_frame_scheduler.sv
// Frame/row sequencer: gates input ready, issues output coordinates once rows are resident.
// Ports: AXI-S valid/last/user/ready, write position, gen handshake + coords, status pulses.
module bdc_frame_scheduler
  import bdc_pkg::*;
#(
  parameter int WIDTH        = 1920,
  parameter int HEIGHT       = 1080,
  parameter int COORD_WIDTH  = CW_DEFAULT,
  parameter int BUFFER_LINES = 4,
  parameter int LEAD_LINES   = 1,
  parameter int SLOT_W       = slot_w(BUFFER_LINES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic                   s_axis_tready,
  output logic [COORD_WIDTH-1:0] wr_x,
  output logic [SLOT_W-1:0]      wr_slot,
  output logic [COORD_WIDTH-1:0] in_lines,
  output logic                   gen_valid,
  input  logic                   gen_ready,
  output logic [COORD_WIDTH-1:0] gen_x,
  output logic [COORD_WIDTH-1:0] gen_y,
  output logic                   gen_sof,
  output logic                   gen_eol,
  output logic                   gen_eof,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_sof,
  output logic                   err_eol
);

  localparam int CW = COORD_WIDTH;
  localparam int BACK_LINES = BUFFER_LINES - LEAD_LINES - 2;

  if (BACK_LINES < 0) begin : g_cfg_err
    $error("BUFFER_LINES too small for LEAD_LINES");
  end

  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);
  localparam logic [CW:0]   H_LAST = (CW+1)'(HEIGHT - 1);
  localparam logic [CW:0]   H_FULL = (CW+1)'(HEIGHT);
  localparam logic [CW:0]   LEAD_W = (CW+1)'(LEAD_LINES);

  state_t state, state_nx;

  logic         rdy_en;
  logic         frame_on;
  logic         in_beat;
  logic         sof_beat;
  logic         err_now;
  logic         cnt_beat;
  logic         gen_fire;
  logic         last_pix;
  logic         row0_ok;
  logic         rowy_ok;
  logic [CW:0]  il_w;
  logic [CW:0]  gy_w;

  // Highest row the window at row y touches, clamped at the frame bottom.
  function automatic logic [CW:0] need_row(
    input logic [CW:0] y
  );
    logic [CW:0] t;
    t = y + LEAD_W;
    return (t > H_LAST) ? H_LAST : t;
  endfunction

  assign il_w     = {1'b0, in_lines};
  assign gy_w     = {1'b0, gen_y};
  assign row0_ok  = il_w > need_row('0);
  assign rowy_ok  = il_w > need_row(gy_w);
  assign frame_on = (state == ST_FILL)
                  | (state == ST_RUN);

  // Input may run at most LEAD+1 rows ahead of out_row,
  // which keeps the slot being written clear of live rows.
  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state)
      ST_IDLE:  s_axis_tready = rdy_en;
      ST_FILL,
      ST_RUN:   s_axis_tready =
                  (il_w <= gy_w + LEAD_W + (CW+1)'(1))
                  && (il_w < H_FULL);
      ST_DRAIN: s_axis_tready = 1'b0;
      default:  s_axis_tready = 1'b0;
    endcase
  end

  assign gen_valid = ((state == ST_RUN)
                   | (state == ST_DRAIN)) & rowy_ok;

  assign in_beat  = s_axis_tvalid & s_axis_tready;
  assign sof_beat = in_beat & s_axis_tuser;
  assign err_now  = sof_beat & (state != ST_IDLE);
  assign cnt_beat = in_beat & ~s_axis_tuser & frame_on;
  assign gen_fire = gen_valid & gen_ready;
  assign last_pix = (gen_x == X_LAST)
                  & (gen_y == Y_LAST);

  assign gen_sof = gen_valid & (gen_x == '0)
                 & (gen_y == '0);
  assign gen_eol = gen_valid & (gen_x == X_LAST);
  assign gen_eof = gen_valid & last_pix;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (sof_beat) state_nx = ST_FILL;
      ST_FILL:
        if (sof_beat)     state_nx = ST_FILL;
        else if (row0_ok) state_nx = ST_RUN;
      ST_RUN:
        if (sof_beat)
          state_nx = ST_FILL;
        else if (gen_fire && last_pix)
          state_nx = ST_IDLE;
        else if (il_w == H_FULL)
          state_nx = ST_DRAIN;
      ST_DRAIN:
        if (gen_fire && last_pix)
          state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rdy_en     <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
      gen_x      <= '0;
      gen_y      <= '0;
    end else begin
      state      <= state_nx;
      rdy_en     <= 1'b1;
      frame_done <= gen_fire & last_pix;
      err_sof    <= err_now;
      if (sof_beat) begin
        gen_x <= '0;
        gen_y <= '0;
      end else if (gen_fire) begin
        if (gen_x == X_LAST) begin
          gen_x <= '0;
          gen_y <= (gen_y == Y_LAST)
                 ? '0 : gen_y + CW'(1);
        end else begin
          gen_x <= gen_x + CW'(1);
        end
      end
    end
  end

  bdc_in_tracker #(
    .WIDTH        (WIDTH),
    .COORD_WIDTH  (COORD_WIDTH),
    .BUFFER_LINES (BUFFER_LINES),
    .SLOT_W       (SLOT_W)
  ) u_in_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (sof_beat),
    .beat     (cnt_beat),
    .tlast    (s_axis_tlast),
    .in_x     (wr_x),
    .in_lines (in_lines),
    .wr_slot  (wr_slot),
    .err_eol  (err_eol)
  );

endmodule

// File: tb/tb_bdc_frame_scheduler.sv
// Testbench for bdc_frame_scheduler: pixel-count reference model, directed + random frames.
// Drives inputs on the falling edge and checks every output there.
module tb_bdc_frame_scheduler;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int BL = 4;
  localparam int LD = 1;
  localparam int CW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic [CW-1:0] wr_x;
  logic [SW-1:0] wr_slot;
  logic [CW-1:0] in_lines;
  logic          gen_valid;
  logic          gen_ready = 1'b0;
  logic [CW-1:0] gen_x;
  logic [CW-1:0] gen_y;
  logic          gen_sof;
  logic          gen_eol;
  logic          gen_eof;
  logic          busy;
  logic          frame_done;
  logic          err_sof;
  logic          err_eol;

  always #5 clk = ~clk;

  bdc_frame_scheduler #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .COORD_WIDTH  (CW),
    .BUFFER_LINES (BL),
    .LEAD_LINES   (LD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .wr_x          (wr_x),
    .wr_slot       (wr_slot),
    .in_lines      (in_lines),
    .gen_valid     (gen_valid),
    .gen_ready     (gen_ready),
    .gen_x         (gen_x),
    .gen_y         (gen_y),
    .gen_sof       (gen_sof),
    .gen_eol       (gen_eol),
    .gen_eof       (gen_eof),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_sof       (err_sof),
    .err_eol       (err_eol)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame progress as linear pixel counts.
  int m_rdy, m_active, m_run, m_in, m_out;
  bit p_sof, p_eol, p_done;

  // Observations of the DUT across a phase.
  int obs_in, obs_gen, obs_eof, obs_eol;
  int first_gv_il, max_il_row0;
  bit seen_gv;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit exp_tready();
    int il;
    il = m_in / W;
    if (m_active == 0) return m_rdy != 0;
    return (il < H) && (il <= m_out / W + LD + 1);
  endfunction

  function automatic bit exp_gv();
    int il;
    il = m_in / W;
    return (m_active != 0) && (m_run != 0)
        && (il > imin(m_out / W + LD, H - 1));
  endfunction

  task automatic model_reset();
    m_rdy = 0; m_active = 0; m_run = 0;
    m_in = 0; m_out = 0;
    p_sof = 0; p_eol = 0; p_done = 0;
  endtask

  task automatic clr_obs();
    obs_in = 0; obs_gen = 0; obs_eof = 0; obs_eol = 0;
    first_gv_il = -1; max_il_row0 = 0; seen_gv = 0;
  endtask

  task automatic check_outputs();
    bit gv;
    gv = exp_gv();
    chk("tready",   s_axis_tready, exp_tready());
    chk("wr_x",     wr_x,     m_in % W);
    chk("wr_slot",  wr_slot,  (m_in / W) % BL);
    chk("in_lines", in_lines, m_in / W);
    chk("gen_valid", gen_valid, gv);
    chk("gen_x",    gen_x,    m_out % W);
    chk("gen_y",    gen_y,    m_out / W);
    chk("gen_sof",  gen_sof,  gv && m_out == 0);
    chk("gen_eol",  gen_eol,  gv && m_out % W == W - 1);
    chk("gen_eof",  gen_eof,  gv && m_out == W * H - 1);
    chk("busy",     busy,     m_active != 0);
    chk("frame_done", frame_done, p_done);
    chk("err_sof",  err_sof,  p_sof);
    chk("err_eol",  err_eol,  p_eol);
  endtask

  // One clock: check, drive, advance the model, wait a cycle.
  task automatic step(input bit tv, input bit tu,
                      input bit tl, input bit gr);
    bit e_tr, e_gv, in_acc, gen_acc;
    bit n_sof, n_eol, n_done;
    int il;
    check_outputs();
    if (gen_valid && !seen_gv) begin
      seen_gv = 1;
      first_gv_il = in_lines;
    end
    if (busy && gen_y == 0 && in_lines > max_il_row0)
      max_il_row0 = in_lines;
    obs_eol += err_eol;
    s_axis_tvalid = tv;
    s_axis_tuser  = tu;
    s_axis_tlast  = tl;
    gen_ready     = gr;
    obs_gen += (gen_valid && gr);
    obs_eof += (gen_eof && gr);
    obs_in  += (tv && s_axis_tready && (tu || busy));
    e_tr = exp_tready();
    e_gv = exp_gv();
    if (!rst_n) begin
      model_reset();
    end else begin
      in_acc  = tv && e_tr;
      gen_acc = e_gv && gr;
      n_sof = 0; n_eol = 0; n_done = 0;
      il = m_in / W;
      if (in_acc && tu) begin
        n_sof = m_active != 0;
        n_eol = tl != (W == 1);
        m_active = 1; m_run = 0;
        m_in = 1; m_out = 0;
      end else begin
        if (m_active != 0 && m_run == 0
            && il > imin(LD, H - 1))
          m_run = 1;
        if (in_acc && m_active != 0) begin
          n_eol = tl != (m_in % W == W - 1);
          m_in++;
        end
        if (gen_acc) begin
          m_out++;
          if (m_out == W * H) begin
            m_out = 0; m_active = 0;
            m_run = 0; n_done = 1;
          end
        end
      end
      m_rdy = 1;
      p_sof = n_sof; p_eol = n_eol; p_done = n_done;
    end
    @(negedge clk);
  endtask

  // Random step; idle beats carry SOF so frames start.
  task automatic fstep(input int tv_pct, input int gr_pct,
                       input int bad_col, input int flip_pct,
                       input int sof_pm);
    bit tv, tu, tl, gr;
    int col;
    tv = $urandom_range(99) < tv_pct;
    gr = $urandom_range(99) < gr_pct;
    tu = tv && (m_active == 0
         || $urandom_range(999) < sof_pm);
    col = tu ? 0 : m_in % W;
    tl = (col == W - 1) || (col == bad_col);
    if ($urandom_range(99) < flip_pct) tl = ~tl;
    step(tv, tu, tl, gr);
  endtask

  task automatic run_until_done(input int tv_pct,
                                input int gr_pct,
                                input int bad_col,
                                input int flip_pct,
                                input int sof_pm,
                                input int limit);
    for (int i = 0; i < limit; i++) begin
      fstep(tv_pct, gr_pct, bad_col, flip_pct, sof_pm);
      if (p_done) break;
    end
    chk("frame_done_seen", frame_done, 1'b1);
  endtask

  initial begin
    model_reset();
    clr_obs();
    @(negedge clk);
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("tready_after_release", s_axis_tready, 1'b1);
    chk("busy_after_release", busy, 1'b0);

    clr_obs();
    run_until_done(100, 100, -1, 0, 0, 400);
    chk("first_gv_in_lines", first_gv_il, 2);
    chk("max_in_lines_row0", max_il_row0, 3);
    chk("gen_beats_free", obs_gen, W * H);
    chk("gen_eof_beats", obs_eof, 1);
    step(0, 0, 0, 1);
    chk("busy_after_done", busy, 1'b0);

    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    step(1, 0, 0, 1);
    chk("idle_discard_wr_x", wr_x, 0);
    chk("idle_discard_busy", busy, 1'b0);

    clr_obs();
    for (int i = 0; i < 60; i++)
      fstep(100, 0, -1, 0, 0);
    chk("stall_in_lines", in_lines, 3);
    chk("stall_tready", s_axis_tready, 1'b0);
    chk("stall_gen_valid", gen_valid, 1'b1);
    run_until_done(100, 100, -1, 0, 0, 400);
    chk("stall_in_beats", obs_in, W * H);
    chk("stall_gen_beats", obs_gen, W * H);

    clr_obs();
    run_until_done(100, 100, 5, 0, 0, 400);
    chk("eol_err_pulses", obs_eol, H);

    for (int i = 0; i < 200; i++) begin
      if (m_active != 0 && m_in == 2 * W + 3) break;
      fstep(100, 100, -1, 0, 0);
    end
    step(1, 1, 0, 1);
    chk("errsof_pulse", err_sof, 1'b1);
    chk("errsof_gen_valid", gen_valid, 1'b0);
    chk("errsof_in_lines", in_lines, 0);
    chk("errsof_wr_x", wr_x, 1);
    chk("errsof_busy", busy, 1'b1);
    run_until_done(100, 100, -1, 0, 0, 400);

    for (int i = 0; i < 200; i++) begin
      if (m_active != 0 && m_out >= 12) break;
      fstep(100, 100, -1, 0, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_gen_valid", gen_valid, 1'b0);
    check_outputs();
    @(negedge clk);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    clr_obs();
    run_until_done(100, 100, -1, 0, 0, 400);
    chk("post_rst_gen_beats", obs_gen, W * H);

    for (int f = 0; f < 6; f++)
      run_until_done(70, 60, -1, 6, 4, 3000);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
